// File: rtl/idli_cmp_m.sv
// -----------------------------------------------------------------------------
// idli_cmp_m -- bit-serial compare unit feeding the predicate register file.
//
// Two operands arrive LSB first, one bit per cycle, over WIDTH cycles. The
// first bit comes with the start pulse. The unit evaluates the latched compare
// op and issues one single-cycle predicate write toward the PRF Q port.
//
// Optional build macro: IDLI_CMP_ACC_EN (compare-and-accumulate). When it is
// defined, i_cmp_acc and i_cmp_acc_data are present. With the latched acc set,
// the written data is ANDed with the current predicate value.
//
// Ports:
//   i_cmp_gck       gated core clock
//   i_cmp_rst_n     asynchronous active-low reset
//   i_cmp_start     start a compare (honoured only when not busy); carries bit 0
//   i_cmp_op[2:0]   compare op, sampled with start
//                   000 EQ, 001 NE, 010 LT, 011 GE, 100 LTU, 101 GEU,
//                   11x reserved (result 0)
//   i_cmp_dst[1:0]  destination predicate P0..P3, sampled with start
//   i_cmp_a/b       operand serial bits
//   i_cmp_acc       (IDLI_CMP_ACC_EN) accumulate enable, sampled with start
//   i_cmp_acc_data  (IDLI_CMP_ACC_EN) current value of dst, sampled in WB
//   o_cmp_busy      compare in flight or writeback pending
//   o_cmp_q[1:0]    predicate write address
//   o_cmp_q_wr_en   predicate write enable, one-cycle pulse
//   o_cmp_q_data    predicate write data (holds its value outside the pulse)
// -----------------------------------------------------------------------------
module idli_cmp_m #(
  parameter int WIDTH = 16
) (
  input  logic       i_cmp_gck,
  input  logic       i_cmp_rst_n,
  input  logic       i_cmp_start,
  input  logic [2:0] i_cmp_op,
  input  logic [1:0] i_cmp_dst,
  input  logic       i_cmp_a,
  input  logic       i_cmp_b,
`ifdef IDLI_CMP_ACC_EN
  input  logic       i_cmp_acc,
  input  logic       i_cmp_acc_data,
`endif
  output logic       o_cmp_busy,
  output logic [1:0] o_cmp_q,
  output logic       o_cmp_q_wr_en,
  output logic       o_cmp_q_data
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [1:0] P3 = 2'd3;  // constant-true predicate, never written

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_EQ  = 3'b000,
    OP_NE  = 3'b001,
    OP_LT  = 3'b010,
    OP_GE  = 3'b011,
    OP_LTU = 3'b100,
    OP_GEU = 3'b101
  } op_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       dst_q, dst_d;
  logic             eq_q, eq_d;     // all bits so far equal
  logic             bor_q, bor_d;   // borrow out of A-B over bits so far
  logic             wr_en_q, wr_en_d;
  logic [1:0]       q_q, q_d;
  logic             data_q, data_d;

  // Per-bit terms of the current serial bit.
  logic bit_eq, bit_bor, eq_fin, bor_fin, lt_fin, result;

  always_comb begin
    bit_eq  = ~(i_cmp_a ^ i_cmp_b);
    bit_bor = ~i_cmp_a & i_cmp_b;
    eq_fin  = eq_q & bit_eq;
    bor_fin = bit_bor | (bit_eq & bor_q);
    // On the final bit the live a/b are the sign bits: if they differ the
    // negative operand is smaller, otherwise the unsigned borrow decides.
    lt_fin  = (i_cmp_a != i_cmp_b) ? i_cmp_a : bor_fin;

    case (op_q)
      OP_EQ:   result = eq_fin;
      OP_NE:   result = ~eq_fin;
      OP_LT:   result = lt_fin;
      OP_GE:   result = ~lt_fin;
      OP_LTU:  result = bor_fin;
      OP_GEU:  result = ~bor_fin;
      default: result = 1'b0;
    endcase
  end

`ifdef IDLI_CMP_ACC_EN
  logic acc_q, acc_d;
  logic acc_gate, wb_data;

  // P3 reads as true; its write is suppressed anyway.
  assign acc_gate = ~acc_q | i_cmp_acc_data | (dst_q == P3);
  // data_q carries the raw result into WB; the accumulate term is applied live
  // because acc_data only becomes valid in the WB cycle.
  assign wb_data  = data_q & acc_gate;
`endif

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dst_d   = dst_q;
    eq_d    = eq_q;
    bor_d   = bor_q;
    wr_en_d = 1'b0;
    q_d     = q_q;
    data_d  = data_q;
`ifdef IDLI_CMP_ACC_EN
    acc_d   = acc_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_cmp_start) begin
          state_d = ST_RUN;
          cnt_d   = CNT_W'(1);
          op_d    = i_cmp_op;
          dst_d   = i_cmp_dst;
          eq_d    = bit_eq;
          bor_d   = bit_bor;
`ifdef IDLI_CMP_ACC_EN
          acc_d   = i_cmp_acc;
`endif
        end
      end

      ST_RUN: begin
        eq_d  = eq_fin;
        bor_d = bor_fin;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_WB;
          cnt_d   = '0;
          wr_en_d = (dst_q != P3);
          // Address/data only move when a write really happens, so they keep
          // reflecting the last issued write.
          if (dst_q != P3) begin
            q_d    = dst_q;
            data_d = result;
          end
        end
      end

      ST_WB: begin
        state_d = ST_IDLE;
`ifdef IDLI_CMP_ACC_EN
        if (wr_en_q) data_d = wb_data;
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_cmp_gck or negedge i_cmp_rst_n) begin
    if (!i_cmp_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      dst_q   <= '0;
      eq_q    <= 1'b0;
      bor_q   <= 1'b0;
      wr_en_q <= 1'b0;
      q_q     <= '0;
      data_q  <= 1'b0;
`ifdef IDLI_CMP_ACC_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      eq_q    <= eq_d;
      bor_q   <= bor_d;
      wr_en_q <= wr_en_d;
      q_q     <= q_d;
      data_q  <= data_d;
`ifdef IDLI_CMP_ACC_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign o_cmp_busy    = (state_q != ST_IDLE);
  assign o_cmp_q       = q_q;
  assign o_cmp_q_wr_en = wr_en_q;
`ifdef IDLI_CMP_ACC_EN
  assign o_cmp_q_data  = (state_q == ST_WB) ? wb_data : data_q;
`else
  assign o_cmp_q_data  = data_q;
`endif

endmodule

// File: tb/tb_idli_cmp_m.sv
// -----------------------------------------------------------------------------
// tb_idli_cmp_m -- self-checking bench for idli_cmp_m (WIDTH = 16).
// Table-driven directed vectors, hand-written corner sequences (back-to-back,
// start while busy, reset mid-compare), then randomized compares checked
// against an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_idli_cmp_m;

  localparam int W = 16;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] op_s;
  logic [1:0] dst_s;
  logic       a_s, b_s;
`ifdef IDLI_CMP_ACC_EN
  logic       acc_s, acc_data_s;
`endif
  logic       busy;
  logic [1:0] q;
  logic       wr_en;
  logic       data;

  int n_checks = 0;
  int n_fail   = 0;

  idli_cmp_m #(.WIDTH(W)) dut (
    .i_cmp_gck      (clk),
    .i_cmp_rst_n    (rst_n),
    .i_cmp_start    (start),
    .i_cmp_op       (op_s),
    .i_cmp_dst      (dst_s),
    .i_cmp_a        (a_s),
    .i_cmp_b        (b_s),
`ifdef IDLI_CMP_ACC_EN
    .i_cmp_acc      (acc_s),
    .i_cmp_acc_data (acc_data_s),
`endif
    .o_cmp_busy     (busy),
    .o_cmp_q        (q),
    .o_cmp_q_wr_en  (wr_en),
    .o_cmp_q_data   (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  dst;
    logic [15:0] a;
    logic [15:0] b;
    logic        exp_data;
  } vec_t;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: predicate computed on whole operands with plain arithmetic.
  function automatic logic model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic signed [15:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return sa < sb;
      3'd3:    return sa >= sb;
      3'd4:    return a < b;
      3'd5:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // One full compare starting in the current cycle. intf_k > 0 pulses a
  // conflicting start with the bit of that index.
  task automatic run_cmp(input logic [2:0] op, input logic [1:0] dst,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic acc, input logic acc_d,
                         input logic exp_raw, input int intf_k, input string tag);
    logic exp_d;
    exp_d = exp_raw & (acc ? acc_d : 1'b1);
    start = 1'b1;
    op_s  = op;
    dst_s = dst;
    a_s   = a[0];
    b_s   = b[0];
`ifdef IDLI_CMP_ACC_EN
    acc_s      = acc;
    acc_data_s = 1'($urandom);
`endif
    tick();
    for (int k = 1; k < W; k++) begin
      check($sformatf("%s busy bit%0d", tag, k), 16'(busy), 16'd1);
      check($sformatf("%s wr_en early bit%0d", tag, k), 16'(wr_en), 16'd0);
      a_s = a[k];
      b_s = b[k];
      if (k == intf_k) begin
        start = 1'b1;
        op_s  = op ^ 3'b001;
        dst_s = dst ^ 2'b01;
      end else begin
        start = 1'b0;
      end
`ifdef IDLI_CMP_ACC_EN
      if (k == W - 1) acc_data_s = acc_d;
`endif
      tick();
    end
    start = 1'b0;
    a_s   = 1'($urandom);
    b_s   = 1'($urandom);
    // Writeback cycle (T+W).
    check({tag, " busy wb"}, 16'(busy), 16'd1);
    check({tag, " wr_en wb"}, 16'(wr_en), (dst != 2'd3) ? 16'd1 : 16'd0);
    if (dst != 2'd3) begin
      check({tag, " q wb"}, 16'(q), 16'(dst));
      check({tag, " data wb"}, 16'(data), 16'(exp_d));
    end
    tick();
    check({tag, " busy after"}, 16'(busy), 16'd0);
    check({tag, " wr_en after"}, 16'(wr_en), 16'd0);
    if (dst != 2'd3) begin
      check({tag, " q hold"}, 16'(q), 16'(dst));
      check({tag, " data hold"}, 16'(data), 16'(exp_d));
    end
  endtask

  initial begin
    vec_t vecs[14];
    logic [15:0] ra, rb;
    logic [2:0]  rop;
    logic [1:0]  rdst;

    vecs[0]  = '{3'd0, 2'd0, 16'h1234, 16'h1234, 1'b1};  // EQ equal
    vecs[1]  = '{3'd4, 2'd1, 16'h0001, 16'hFFFF, 1'b1};  // LTU
    vecs[2]  = '{3'd2, 2'd1, 16'h0001, 16'hFFFF, 1'b0};  // LT: 1 < -1 false
    vecs[3]  = '{3'd3, 2'd0, 16'h8000, 16'h7FFF, 1'b0};  // GE: min >= max false
    vecs[4]  = '{3'd5, 2'd2, 16'h8000, 16'h7FFF, 1'b1};  // GEU
    vecs[5]  = '{3'd1, 2'd2, 16'hFFFF, 16'h7FFF, 1'b1};  // NE differs in MSB
    vecs[6]  = '{3'd0, 2'd3, 16'h5A5A, 16'h5A5A, 1'b1};  // P3: no write
    vecs[7]  = '{3'd6, 2'd0, 16'h0000, 16'h0000, 1'b0};  // reserved
    vecs[8]  = '{3'd7, 2'd1, 16'h0003, 16'h0009, 1'b0};  // reserved
    vecs[9]  = '{3'd2, 2'd2, 16'h8000, 16'h0001, 1'b1};  // LT negative < positive
    vecs[10] = '{3'd4, 2'd0, 16'h8000, 16'h0001, 1'b0};  // LTU same operands
    vecs[11] = '{3'd5, 2'd1, 16'hABCD, 16'hABCD, 1'b1};  // GEU equal
    vecs[12] = '{3'd0, 2'd2, 16'h0000, 16'h0001, 1'b0};  // EQ differs in LSB
    vecs[13] = '{3'd2, 2'd0, 16'h4321, 16'h4321, 1'b0};  // LT equal

    rst_n = 1'b0;
    start = 1'b0;
    op_s  = '0;
    dst_s = '0;
    a_s   = 1'b0;
    b_s   = 1'b0;
`ifdef IDLI_CMP_ACC_EN
    acc_s      = 1'b0;
    acc_data_s = 1'b0;
`endif
    tick();
    tick();
    check("reset busy", 16'(busy), 16'd0);
    check("reset wr_en", 16'(wr_en), 16'd0);
    check("reset q", 16'(q), 16'd0);
    check("reset data", 16'(data), 16'd0);
    rst_n = 1'b1;
    tick();
    check("idle busy", 16'(busy), 16'd0);

    // Directed table; consecutive calls also exercise back-to-back starts.
    for (int i = 0; i < 14; i++)
      run_cmp(vecs[i].op, vecs[i].dst, vecs[i].a, vecs[i].b, 1'b0, 1'b0,
              vecs[i].exp_data, 0, $sformatf("vec%0d", i));

    // Start pulsed at T+3 with different op/dst must be ignored.
    run_cmp(3'd4, 2'd1, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b1, 3, "start_busy");
    run_cmp(3'd0, 2'd2, 16'hCAFE, 16'hCAFF, 1'b0, 1'b0, 1'b0, 3, "start_busy2");

    // Reset mid-RUN: busy drops at once, no write pulse, then a clean compare.
    start = 1'b1;
    op_s  = 3'd0;
    dst_s = 2'd1;
    a_s   = 1'b1;
    b_s   = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    check("pre-reset busy", 16'(busy), 16'd1);
    rst_n = 1'b0;
    #1;
    check("mid reset busy", 16'(busy), 16'd0);
    check("mid reset wr_en", 16'(wr_en), 16'd0);
    check("mid reset q", 16'(q), 16'd0);
    check("mid reset data", 16'(data), 16'd0);
    tick();
    check("in reset busy", 16'(busy), 16'd0);
    rst_n = 1'b1;
    for (int k = 0; k < W + 2; k++) begin
      tick();
      check($sformatf("post reset idle busy %0d", k), 16'(busy), 16'd0);
      check($sformatf("post reset idle wr_en %0d", k), 16'(wr_en), 16'd0);
    end
    run_cmp(3'd0, 2'd0, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1, 0, "after_reset");

`ifdef IDLI_CMP_ACC_EN
    run_cmp(3'd0, 2'd1, 16'h0F0F, 16'h0F0F, 1'b1, 1'b0, 1'b1, 0, "acc1_d0");
    run_cmp(3'd0, 2'd1, 16'h0F0F, 16'h0F0F, 1'b1, 1'b1, 1'b1, 0, "acc1_d1");
    run_cmp(3'd0, 2'd2, 16'h0F0F, 16'h0F0F, 1'b0, 1'b0, 1'b1, 0, "acc0_d0");
    run_cmp(3'd0, 2'd3, 16'h0F0F, 16'h0F0F, 1'b1, 1'b0, 1'b1, 0, "acc_p3");
`endif

    // Randomized compares against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ 16'h8000;
        default: rb = 16'($urandom);
      endcase
      rop  = 3'($urandom_range(0, 7));
      rdst = 2'($urandom_range(0, 3));
      run_cmp(rop, rdst, ra, rb, 1'b0, 1'b0, model(rop, ra, rb), 0,
              $sformatf("rand%0d op%0d %h/%h", i, rop, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
